// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-port RAM with a tristate data bus
module mem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic [DW-1:0] a_rdata,
   output logic          a_ack,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic [DW-1:0] b_rdata,
   output logic          b_ack,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic          ram_oe,
   inout  wire  [DW-1:0] ram_data,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state_q, state_d;
   logic          last_b_q, last_b_d;
   logic          win_b_q, win_b_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] a_rdata_q, a_rdata_d;
   logic [DW-1:0] b_rdata_q, b_rdata_d;
   logic          pick_b;

   // B wins when it is alone, or on a tie when A was granted last.
   assign pick_b = b_req && (!a_req || !last_b_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_b_q  <= 1'b1;
         win_b_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         last_b_q  <= last_b_d;
         win_b_q   <= win_b_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_b_d  = last_b_q;
      win_b_d   = win_b_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               win_b_d  = pick_b;
               last_b_d = pick_b;
               we_d     = pick_b ? b_we    : a_we;
               addr_d   = pick_b ? b_addr  : a_addr;
               wdata_d  = pick_b ? b_wdata : a_wdata;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (!we_q) begin
               if (win_b_q) b_rdata_d = ram_data;
               else         a_rdata_d = ram_data;
            end
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ram_addr is the latched address, so it naturally holds outside ACCESS.
   assign ram_addr = addr_q;
   assign ram_we   = (state_q == ACCESS) && we_q;
   assign ram_oe   = (state_q == ACCESS) && !we_q;
   assign ram_data = (ram_we && !ram_oe) ? wdata_q : {DW{1'bz}};
   assign a_ack    = (state_q == RESP) && !win_b_q;
   assign b_ack    = (state_q == RESP) && win_b_q;
   assign busy     = (state_q != IDLE);
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scenarios plus randomized requesters checked against a transaction-level model
module tb_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          a_ack, b_ack;
   logic [AW-1:0] ram_addr;
   logic          ram_we, ram_oe, busy;
   wire  [DW-1:0] ram_data;

   logic [DW-1:0] ram [256];
   logic [DW-1:0] idle_pat;

   int tests = 0;
   int fails = 0;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata), .a_ack(a_ack),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(b_rdata), .b_ack(b_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe),
      .ram_data(ram_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM model: drives the bus on reads, a marker pattern when idle, nothing while the block writes.
   assign ram_data = ram_we ? {DW{1'bz}} : (ram_oe ? ram[ram_addr] : idle_pat);
   always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_data;

   // Transaction-level reference: cycles elapsed since grant plus the granted request.
   int            m_since;
   bit            m_last_b, m_win_b, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_ra, m_rb;
   logic [DW-1:0] m_mem [256];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_since  = 0;
      m_last_b = 1'b1;
      m_win_b  = 1'b0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      m_ra     = '0;
      m_rb     = '0;
   endtask

   task automatic model_step();
      if (m_since == 0) begin
         if (a_req || b_req) begin
            m_win_b  = (a_req && b_req) ? !m_last_b : b_req;
            m_last_b = m_win_b;
            m_we     = m_win_b ? b_we : a_we;
            m_addr   = m_win_b ? b_addr : a_addr;
            m_wdata  = m_win_b ? b_wdata : a_wdata;
            m_since  = 1;
         end
      end else if (m_since == 1) begin
         if (m_we) m_mem[m_addr] = m_wdata;
         else if (m_win_b) m_rb = m_mem[m_addr];
         else m_ra = m_mem[m_addr];
         m_since = 2;
      end else begin
         m_since = 0;
      end
   endtask

   task automatic check_all();
      logic acc;
      acc = (m_since == 1);
      chk("busy", busy, m_since != 0);
      chk("ram_we", ram_we, acc && m_we);
      chk("ram_oe", ram_oe, acc && !m_we);
      chk("we_oe_excl", ram_we & ram_oe, 0);
      chk("ram_addr", ram_addr, m_addr);
      chk("a_ack", a_ack, (m_since == 2) && !m_win_b);
      chk("b_ack", b_ack, (m_since == 2) && m_win_b);
      chk("a_rdata", a_rdata, m_ra);
      chk("b_rdata", b_rdata, m_rb);
      if (acc && m_we) chk("ram_data_wr", ram_data, m_wdata);
      else if (acc)    chk("ram_data_rd", ram_data, m_mem[m_addr]);
      else             chk("ram_data_hiz", ram_data, idle_pat);
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
   endtask

   task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_all();
   endtask

   initial begin
      bit pa, pb;
      idle_pat = 8'hC3;
      for (int i = 0; i < 256; i++) begin
         ram[i]   = '0;
         m_mem[i] = '0;
      end
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_addr", ram_addr, 0);

      // A writes 0x5A to 0x10
      set_a(1, 1, 8'h10, 8'h5A);
      tick();
      chk("wr_ram_we", ram_we, 1);
      chk("wr_ram_data", ram_data, 8'h5A);
      chk("wr_ram_addr", ram_addr, 8'h10);
      tick();
      chk("wr_a_ack", a_ack, 1);
      chk("wr_we_gone", ram_we, 0);
      set_a(0, 0, 0, 0);
      tick();
      chk("wr_ram_content", ram[8'h10], 8'h5A);

      // B reads 0x10 back
      set_b(1, 0, 8'h10, 8'h00);
      tick();
      chk("rd_ram_oe", ram_oe, 1);
      chk("rd_bus", ram_data, 8'h5A);
      tick();
      chk("rd_b_ack", b_ack, 1);
      chk("rd_b_rdata", b_rdata, 8'h5A);
      chk("rd_a_rdata_hold", a_rdata, 8'h00);
      set_b(0, 0, 0, 0);
      tick();

      // address change during ACCESS must not affect the access
      set_a(1, 0, 8'h20, 8'h00);
      tick();
      a_addr = 8'h30;
      chk("latch_addr", ram_addr, 8'h20);
      tick();
      chk("latch_ack", a_ack, 1);
      set_a(0, 0, 0, 0);
      tick();

      // reset mid-ACCESS of a write
      set_a(1, 1, 8'h40, 8'h77);
      tick();
      chk("abort_we_before", ram_we, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_we", ram_we, 0);
      chk("abort_busy", busy, 0);
      chk("abort_a_ack", a_ack, 0);
      chk("abort_addr", ram_addr, 0);
      chk("abort_rdata", b_rdata, 0);
      do_reset();
      repeat (3) tick();
      chk("abort_no_ack", a_ack | b_ack, 0);

      // simultaneous requests straight after reset: A, B, A, B every 3 cycles
      set_a(1, 1, 8'h01, 8'h11);
      set_b(1, 1, 8'h02, 8'h22);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("rr_a_ack", a_ack, (i == 1) || (i == 7));
         chk("rr_b_ack", b_ack, (i == 4) || (i == 10));
      end
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      tick();
      chk("rr_mem_a", ram[8'h01], 8'h11);
      chk("rr_mem_b", ram[8'h02], 8'h22);

      // randomized requesters obeying the hold-until-ack protocol
      pa = 0;
      pb = 0;
      for (int c = 0; c < 3000; c++) begin
         logic [2:0] sel;
         if (a_ack) pa = 0;
         if (b_ack) pb = 0;
         if (!pa && ($urandom % 3 == 0)) pa = 1;
         if (!pb && ($urandom % 3 == 0)) pb = 1;
         sel = 3'($urandom % 8);
         a_req = pa; a_we = 1'($urandom); a_wdata = 8'($urandom);
         a_addr = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom % 16);
         sel = 3'($urandom % 8);
         b_req = pb; b_we = 1'($urandom); b_wdata = 8'($urandom);
         b_addr = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom % 16);
         idle_pat = 8'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, RAM address width.
REQ-002 The block SHALL have parameter DW, default 8, RAM data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all registers are posedge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port a_req, input, 1, port A access request, held until a_ack.
REQ-006 The block SHALL have port a_we, input, 1, port A direction (1 = write, 0 = read).
REQ-007 The block SHALL have port a_addr, input, AW, port A address.
REQ-008 The block SHALL have port a_wdata, input, DW, port A write data.
REQ-009 The block SHALL have port a_rdata, output, DW, port A registered read data.
REQ-010 The block SHALL have port a_ack, output, 1, port A one-cycle completion pulse.
REQ-011 The block SHALL have ports b_req, b_we, b_addr, b_wdata, b_rdata and b_ack, identical to port A and prefixed b_.
REQ-012 The block SHALL have port ram_addr, output, AW, RAM address.
REQ-013 The block SHALL have port ram_we, output, 1, RAM write enable.
REQ-014 The block SHALL have port ram_oe, output, 1, RAM output enable.
REQ-015 The block SHALL have port ram_data, inout, DW, bidirectional RAM data bus.
REQ-016 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS (any req high at the edge), ACCESS->RESP (always) and RESP->IDLE (always).
REQ-018 Requests SHALL be sampled only at the edge ending an IDLE cycle; req levels during ACCESS and RESP SHALL be ignored.
REQ-019 At the IDLE->ACCESS edge, the winner's we, addr and wdata SHALL be latched, and the latched values SHALL drive the transaction regardless of later changes to the inputs.
REQ-020 Arbitration SHALL be round-robin: with both reqs high, the port not granted last wins; with one req high, that port wins; the last-grant register SHALL update only on grant.
REQ-021 In ACCESS for a write: ram_addr = latched addr, ram_we = 1, ram_oe = 0, ram_data driven with latched wdata; the RAM stores the data at the edge ending ACCESS.
REQ-022 In ACCESS for a read: ram_addr = latched addr, ram_oe = 1, ram_we = 0, ram_data undriven (high-Z); ram_data SHALL be captured into the winner's rdata at the edge ending ACCESS.
REQ-023 In IDLE and RESP: ram_we = 0, ram_oe = 0, ram_data high-Z, and ram_addr holds its last value.
REQ-024 The block SHALL drive ram_data only when ram_we = 1 and ram_oe = 0; ram_we and ram_oe SHALL never both be 1.
REQ-025 In RESP, exactly the winner's ack SHALL be 1 for one cycle; both acks SHALL be 0 in all other states.
REQ-026 Latency SHALL be a fixed 3 cycles from the sampling IDLE cycle to the ack cycle inclusive, giving a peak rate of one access per 3 cycles.
REQ-027 A requester SHALL drop req in the cycle after ack; a req still high in the following IDLE SHALL be treated as a new request (back-to-back allowed).
REQ-028 a_rdata and b_rdata SHALL change only on a read completion by their own port and SHALL hold their value otherwise, including across writes and the other port's reads.
REQ-029 Every addr value 0..2^AW-1 SHALL be legal, with no wrap or range checks.

Reset
REQ-030 On rst_n = 0, asynchronously and without waiting for clk: state = IDLE, ram_we = 0, ram_oe = 0, ram_data high-Z, ram_addr = 0, a_ack = b_ack = 0, a_rdata = b_rdata = 0, busy = 0, last-grant = B (so A wins the first tie).
REQ-031 A reset asserted during ACCESS SHALL abort the transaction with no ack; a write is not guaranteed to have reached the RAM.
REQ-032 After rst_n deasserts, the first request SHALL be sampled at the first edge on which rst_n = 1 and the state is IDLE.

Verification
REQ-033 Scenario: A writes 0x5A to 0x10 with a_req held -> ram_we = 1 and ram_data = 0x5A for exactly one cycle, then a_ack on cycle 3 and RAM[0x10] = 0x5A.
REQ-034 Scenario: B reads 0x10 after that write -> ram_oe = 1 for one cycle with ram_data not driven by the block, then b_ack with b_rdata = 0x5A and a_rdata unchanged.
REQ-035 Scenario: a_req and b_req high together straight after reset, held for 4 transactions -> grant order A, B, A, B with 4 acks at 3-cycle spacing.
REQ-036 Scenario: a_addr changed from 0x20 to 0x30 during ACCESS -> the access uses 0x20.
REQ-037 Scenario: rst_n pulsed low mid-ACCESS of a write -> ram_we drops immediately, no ack is issued, state = IDLE, and all outputs take their reset values.
REQ-038 Scenario: a checker on every cycle -> ram_we and ram_oe are never both 1, and ram_data is high-Z whenever ram_we = 0.
